// File: rtl/ic_arbiter.sv
// Multi-requester arbiter in front of a single burst peripheral: IDLE -> ADDR -> DATA per transfer.
// Define IC_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module ic_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           req_wr,
    input  logic [3*NREQ-1:0]         req_addr,
    input  logic [3*NREQ-1:0]         req_len,
    input  logic [4*NREQ-1:0]         req_wdata,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           wbeat,
    output logic                      rvalid,
    output logic [$clog2(NREQ)-1:0]   rid,
    output logic [3:0]                rdata_o,
    output logic                      busy,
    output logic [2:0]                m_address,
    output logic                      m_wr,
    output logic                      m_rd,
    output logic [2:0]                m_length,
    output logic [3:0]                m_wdata,
    input  logic [3:0]                m_rdata
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic             wr_q, wr_d;
    logic [2:0]       addr_q, addr_d;
    logic [2:0]       len_q, len_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             rvalid_q, rvalid_d;
    logic [IDW-1:0]   rid_q, rid_d;
    logic [3:0]       rdata_q, rdata_d;

    logic             win_vld;
    logic [IDW-1:0]   win_idx;

`ifdef IC_ARB_RR_EN
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW:0]     rr_sum;

    // Scan from the pointer upward with wrap; descending k lets the nearest hit win.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        rr_sum  = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            rr_sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (rr_sum >= (IDW+1)'(NREQ))
                rr_sum = rr_sum - (IDW+1)'(NREQ);
            if (req[rr_sum[IDW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = rr_sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && win_vld)
            ptr_d = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + 1'b1;
    end
`else
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (req[IDW'(i)]) begin
                win_vld = 1'b1;
                win_idx = IDW'(i);
            end
        end
    end
`endif

    // State register: every flop clears asynchronously so outputs drop with resetn.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
`ifdef IC_ARB_RR_EN
            ptr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
`ifdef IC_ARB_RR_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    // Next-state: the request is latched at grant, so requester-side changes afterwards are ignored.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = ADDR;
                    owner_d = win_idx;
                    wr_d    = req_wr[win_idx];
                    addr_d  = 3'(req_addr >> (3*win_idx));
                    len_d   = 3'(req_len >> (3*win_idx));
                end
            end
            ADDR: begin
                if (len_q == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    cnt_d   = len_q;
                end
            end
            DATA: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        rvalid_d = (state_q == DATA) && !wr_q;
        rid_d    = rvalid_d ? owner_q : '0;
        rdata_d  = rvalid_d ? m_rdata : 4'd0;
    end

    always_comb begin
        gnt       = '0;
        wbeat     = '0;
        m_address = '0;
        m_wr      = 1'b0;
        m_rd      = 1'b0;
        m_length  = '0;
        m_wdata   = '0;
        busy      = (state_q != IDLE);
        case (state_q)
            ADDR: begin
                gnt       = NREQ'(1) << owner_q;
                m_address = addr_q;
                m_length  = len_q;
                m_wr      = wr_q;
                m_rd      = !wr_q;
            end
            DATA: begin
                if (wr_q) begin
                    wbeat   = NREQ'(1) << owner_q;
                    m_wdata = 4'(req_wdata >> (4*owner_q));
                end
            end
            default: ;
        endcase
    end

    assign rvalid  = rvalid_q;
    assign rid     = rid_q;
    assign rdata_o = rdata_q;

endmodule
